ws2812_out_ctl: RTL and testbench
=================================

WS2812_OUT_CTL -- requirements
Module: ws2812_out_ctl

Interface
REQ-001 SHALL have parameter PIXEL_BITS, default 24, giving the bits per pixel word (24 = GRB, 32 = RGBW).
REQ-002 SHALL have port clk_i, input, 1 bit: system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start_i, input, 1 bit: frame-start pulse, driven by the channel's RAM write-done strobe.
REQ-005 SHALL have port reg_chan_len_i, input, 8 bits: index of the last pixel; a frame holds reg_chan_len_i+1 pixels.
REQ-006 SHALL have ports reg_t0h_i, reg_t0l_i, reg_t1h_i and reg_t1l_i, input, 8 bits each: high and low phase lengths, in clk_i cycles, for code-0 and code-1 bits.
REQ-007 SHALL have port reg_rst_i, input, 16 bits: length of the frame-end low gap, in clk_i cycles.
REQ-008 SHALL have port ram_rd_en_o, output, 1 bit: pixel RAM read strobe.
REQ-009 SHALL have port ram_rd_addr_o, output, 8 bits: pixel RAM read address.
REQ-010 SHALL have port ram_rd_data_i, input, PIXEL_BITS bits: RAM read data, valid exactly 1 cycle after ram_rd_en_o.
REQ-011 SHALL have port bit_code_o, output, 1 bit: serial NRZ line to the LED string.
REQ-012 SHALL have port busy_o, output, 1 bit: high while a frame is in progress.
REQ-013 SHALL have port done_o, output, 1 bit: 1-cycle pulse at frame completion.

Function
REQ-014 SHALL implement FSM states IDLE, READ, LOAD, SEND_H, SEND_L and GAP.
REQ-015 IDLE: when start_i=1 at cycle k, SHALL move to READ; busy_o=1 from cycle k+1.
REQ-016 READ (cycle k+1): ram_rd_en_o=1, ram_rd_addr_o=0.
REQ-017 LOAD (cycle k+2): SHALL capture ram_rd_data_i into the shift register and clear the pixel and bit counters.
REQ-018 SEND_H SHALL first be entered at cycle k+3, when bit_code_o first goes high.
REQ-019 Bits SHALL be sent MSB first; the current bit is shift-register bit PIXEL_BITS-1.
REQ-020 A 0 bit SHALL be bit_code_o=1 for reg_t0h_i cycles (SEND_H), then 0 for reg_t0l_i cycles (SEND_L).
REQ-021 A 1 bit SHALL use reg_t1h_i and reg_t1l_i the same way.
REQ-022 Any timing value of 0 SHALL be treated as 1.
REQ-023 The timing registers SHALL be sampled at the start of each phase; changes mid-phase take effect at the next phase.
REQ-024 Prefetch: in the first SEND_H cycle of bit 0 of pixel p < reg_chan_len_i, SHALL assert ram_rd_en_o for 1 cycle with ram_rd_addr_o=p+1.
REQ-025 The cycle after a prefetch, SHALL capture ram_rd_data_i into a next-pixel buffer.
REQ-026 At the end of SEND_L of bit PIXEL_BITS-1, if more pixels remain, SHALL load the buffer into the shift register and enter SEND_H with no extra cycles, so the line has no inter-pixel gap.
REQ-027 At the end of SEND_L of the last bit of pixel reg_chan_len_i, SHALL enter GAP with bit_code_o=0.
REQ-028 GAP SHALL last max(reg_rst_i,1) cycles, then return to IDLE.
REQ-029 In the last GAP cycle, done_o SHALL be 1; busy_o SHALL be 0 from the following cycle.
REQ-030 Pixel counter SHALL be 8 bits; reg_chan_len_i=255 SHALL send 256 pixels with no wrap before completion.
REQ-031 reg_chan_len_i SHALL be sampled at the start_i acceptance.
REQ-032 start_i SHALL be ignored while busy_o=1, including in the same cycle as done_o.
REQ-033 ram_rd_en_o SHALL never be asserted outside READ and the prefetch cycle.
REQ-034 ram_rd_addr_o SHALL hold its last value when ram_rd_en_o=0.
REQ-035 bit_code_o SHALL be 0 in IDLE, SEND_L and GAP.
REQ-036 bit_code_o, busy_o and done_o SHALL be registered outputs.

Reset
REQ-037 While rst_n_i=0, SHALL hold state=IDLE, bit_code_o=0, busy_o=0, done_o=0, ram_rd_en_o=0, ram_rd_addr_o=0, and all counters, shift register and buffer at 0.
REQ-038 Reset asserted mid-frame SHALL abort immediately with bit_code_o=0 and no done_o.
REQ-039 After reset release, the block SHALL wait in IDLE for the next start_i.

Verification
REQ-040 Single pixel: len=0, t0h=3, t0l=7, t1h=7, t1l=3, rst=20, data 0xA50000 -> 24 bits 1,0,1,0,0,1,0,1,0x16 with exact phase lengths; done_o 1 cycle after 20 gap cycles.
REQ-041 Three pixels: len=2, data 0xFFFFFF/0x000000/0x123456 -> reads at addr 0,1,2 only; no extra low cycles between pixels; total length 3 + 3*24*10 + 20 cycles.
REQ-042 Start while busy: start_i pulsed mid-frame and again on the done_o cycle -> both ignored; one frame only.
REQ-043 Reset mid-frame: rst_n_i low during pixel 1 bit 5 -> bit_code_o=0 immediately; no done_o; a new start_i then sends a clean frame from addr 0.
REQ-044 Zero timing: all timing values 0 and reg_rst_i=0 -> every phase 1 cycle, gap 1 cycle.
REQ-045 Full channel: len=255, PIXEL_BITS=32 -> 256 reads with addresses 0..255 in order, no wrap to 0.

Source files
------------

// File: rtl/ws2812_out_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_out_ctl
//  Description : WS2812-style serial LED line driver. Reads one pixel word per
//                LED from pixel RAM and sends it MSB first as NRZ code bits.
//                Each bit is a high phase followed by a low phase, with phase
//                lengths set by the timing registers. A low reset gap ends
//                the frame. The next pixel is prefetched into a buffer so
//                there is no gap on the line between pixels.
//  Ports       : clk_i           - system clock, rising edge
//                rst_n_i         - asynchronous active-low reset
//                start_i         - frame start pulse (ignored while busy)
//                reg_chan_len_i  - index of last pixel (frame = len+1 pixels)
//                reg_t0h/t0l_i   - code-0 high/low lengths in clk cycles
//                reg_t1h/t1l_i   - code-1 high/low lengths in clk cycles
//                reg_rst_i       - frame-end low gap length in clk cycles
//                ram_rd_en_o     - pixel RAM read strobe
//                ram_rd_addr_o   - pixel RAM read address
//                ram_rd_data_i   - pixel RAM data, valid 1 cycle after strobe
//                bit_code_o      - serial line to the LED string
//                busy_o          - frame in progress
//                done_o          - 1-cycle pulse in the last gap cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_out_ctl #(
   parameter int PIXEL_BITS = 24
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  start_i,
   input  logic [7:0]            reg_chan_len_i,
   input  logic [7:0]            reg_t0h_i,
   input  logic [7:0]            reg_t0l_i,
   input  logic [7:0]            reg_t1h_i,
   input  logic [7:0]            reg_t1l_i,
   input  logic [15:0]           reg_rst_i,
   output logic                  ram_rd_en_o,
   output logic [7:0]            ram_rd_addr_o,
   input  logic [PIXEL_BITS-1:0] ram_rd_data_i,
   output logic                  bit_code_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int            BIT_W    = $clog2(PIXEL_BITS);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PIXEL_BITS - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      READ   = 3'd1,
      LOAD   = 3'd2,
      SEND_H = 3'd3,
      SEND_L = 3'd4,
      GAP    = 3'd5
   } state_t;

   state_t                state, state_nxt;
   logic [15:0]           cnt, cnt_nxt;           // remaining cycles of phase, minus 1
   logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt;
   logic [7:0]            pix_cnt, pix_cnt_nxt;
   logic [7:0]            chan_len, chan_len_nxt;
   logic [PIXEL_BITS-1:0] shreg, shreg_nxt;
   logic [PIXEL_BITS-1:0] pix_buf, pix_buf_nxt;
   logic                  pf_cap, pf_cap_nxt;     // prefetch data arrives this cycle
   logic                  rd_en_nxt;
   logic [7:0]            rd_addr_nxt;
   logic                  bit_nxt, busy_nxt, done_nxt;

   // Phase length minus one, with a programmed 0 behaving as 1.
   function automatic logic [15:0] phase_m1(input logic [7:0] len);
      return (len == 8'd0) ? 16'd0 : {8'd0, len - 8'd1};
   endfunction

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_cnt       <= '0;
         pix_cnt       <= '0;
         chan_len      <= '0;
         shreg         <= '0;
         pix_buf       <= '0;
         pf_cap        <= 1'b0;
         ram_rd_en_o   <= 1'b0;
         ram_rd_addr_o <= '0;
         bit_code_o    <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         bit_cnt       <= bit_cnt_nxt;
         pix_cnt       <= pix_cnt_nxt;
         chan_len      <= chan_len_nxt;
         shreg         <= shreg_nxt;
         pix_buf       <= pix_buf_nxt;
         pf_cap        <= pf_cap_nxt;
         ram_rd_en_o   <= rd_en_nxt;
         ram_rd_addr_o <= rd_addr_nxt;
         bit_code_o    <= bit_nxt;
         busy_o        <= busy_nxt;
         done_o        <= done_nxt;
      end
   end

   // All outputs are registered, so every decision below is made one cycle
   // ahead: the values computed here appear on the pins in the next state.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      bit_cnt_nxt  = bit_cnt;
      pix_cnt_nxt  = pix_cnt;
      chan_len_nxt = chan_len;
      shreg_nxt    = shreg;
      pix_buf_nxt  = pix_buf;
      rd_en_nxt    = 1'b0;
      rd_addr_nxt  = ram_rd_addr_o;
      bit_nxt      = 1'b0;
      busy_nxt     = busy_o;
      done_nxt     = 1'b0;

      // The only read issued from SEND_H is the prefetch.
      pf_cap_nxt = ram_rd_en_o && (state == SEND_H);
      if (pf_cap) begin
         pix_buf_nxt = ram_rd_data_i;
      end

      case (state)
         IDLE: begin
            if (start_i) begin
               state_nxt    = READ;
               busy_nxt     = 1'b1;
               chan_len_nxt = reg_chan_len_i;
               rd_en_nxt    = 1'b1;
               rd_addr_nxt  = 8'd0;
            end
         end

         READ: begin
            state_nxt = LOAD;
         end

         LOAD: begin
            shreg_nxt   = ram_rd_data_i;
            bit_cnt_nxt = '0;
            pix_cnt_nxt = 8'd0;
            state_nxt   = SEND_H;
            bit_nxt     = 1'b1;
            cnt_nxt     = phase_m1(ram_rd_data_i[PIXEL_BITS-1] ? reg_t1h_i : reg_t0h_i);
            if (chan_len != 8'd0) begin
               rd_en_nxt   = 1'b1;
               rd_addr_nxt = 8'd1;
            end
         end

         SEND_H: begin
            if (cnt == 16'd0) begin
               state_nxt = SEND_L;
               cnt_nxt   = phase_m1(shreg[PIXEL_BITS-1] ? reg_t1l_i : reg_t0l_i);
            end else begin
               cnt_nxt = cnt - 16'd1;
               bit_nxt = 1'b1;
            end
         end

         SEND_L: begin
            if (cnt != 16'd0) begin
               cnt_nxt = cnt - 16'd1;
            end else if (bit_cnt == LAST_BIT) begin
               if (pix_cnt == chan_len) begin
                  state_nxt = GAP;
                  cnt_nxt   = (reg_rst_i == 16'd0) ? 16'd0 : reg_rst_i - 16'd1;
                  done_nxt  = (reg_rst_i <= 16'd1);
               end else begin
                  // Move straight to the buffered pixel with no idle cycle.
                  pix_cnt_nxt = pix_cnt + 8'd1;
                  bit_cnt_nxt = '0;
                  shreg_nxt   = pix_buf;
                  state_nxt   = SEND_H;
                  bit_nxt     = 1'b1;
                  cnt_nxt     = phase_m1(pix_buf[PIXEL_BITS-1] ? reg_t1h_i : reg_t0h_i);
                  if ((pix_cnt + 8'd1) < chan_len) begin
                     rd_en_nxt   = 1'b1;
                     rd_addr_nxt = pix_cnt + 8'd2;
                  end
               end
            end else begin
               bit_cnt_nxt = bit_cnt + 1'b1;
               shreg_nxt   = {shreg[PIXEL_BITS-2:0], 1'b0};
               state_nxt   = SEND_H;
               bit_nxt     = 1'b1;
               cnt_nxt     = phase_m1(shreg[PIXEL_BITS-2] ? reg_t1h_i : reg_t0h_i);
            end
         end

         GAP: begin
            if (cnt == 16'd0) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end else begin
               cnt_nxt  = cnt - 16'd1;
               done_nxt = (cnt == 16'd1);
            end
         end

         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_out_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws2812_out_ctl
//  Description : Self-checking bench for ws2812_out_ctl. A 24-bit instance
//                covers line timing, prefetch, busy/done and reset abort; a
//                32-bit instance covers a full 256-pixel channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_out_ctl;

   logic        clk = 1'b0;
   logic        rst_n_i;
   logic [7:0]  t0h, t0l, t1h, t1l;
   logic [15:0] reg_rst;

   // 24-bit instance
   logic        start_a;
   logic [7:0]  len_a;
   logic        rd_en_a, bit_code_a, busy_a, done_a;
   logic [7:0]  rd_addr_a;
   logic [23:0] rd_data_a;

   // 32-bit instance
   logic        start_b;
   logic [7:0]  len_b;
   logic        rd_en_b, bit_code_b, busy_b, done_b;
   logic [7:0]  rd_addr_b;
   logic [31:0] rd_data_b;

   logic [31:0] mem [256];

   int checks   = 0;
   int failures = 0;
   int done_cnt_a  = 0;
   int busy_cnt_b  = 0;
   int frames_a    = 0;

   // Expected {bit_code, busy, done} per cycle, and expected read addresses.
   logic [2:0] exp_line [$];
   logic [7:0] exp_rd   [$];
   logic [7:0] exp_rd_b [$];
   logic [2:0] e_line;

   always #5 clk = ~clk;

   ws2812_out_ctl #(.PIXEL_BITS(24)) u_dut_a (
      .clk_i          (clk),
      .rst_n_i        (rst_n_i),
      .start_i        (start_a),
      .reg_chan_len_i (len_a),
      .reg_t0h_i      (t0h),
      .reg_t0l_i      (t0l),
      .reg_t1h_i      (t1h),
      .reg_t1l_i      (t1l),
      .reg_rst_i      (reg_rst),
      .ram_rd_en_o    (rd_en_a),
      .ram_rd_addr_o  (rd_addr_a),
      .ram_rd_data_i  (rd_data_a),
      .bit_code_o     (bit_code_a),
      .busy_o         (busy_a),
      .done_o         (done_a)
   );

   ws2812_out_ctl #(.PIXEL_BITS(32)) u_dut_b (
      .clk_i          (clk),
      .rst_n_i        (rst_n_i),
      .start_i        (start_b),
      .reg_chan_len_i (len_b),
      .reg_t0h_i      (t0h),
      .reg_t0l_i      (t0l),
      .reg_t1h_i      (t1h),
      .reg_t1l_i      (t1l),
      .reg_rst_i      (reg_rst),
      .ram_rd_en_o    (rd_en_b),
      .ram_rd_addr_o  (rd_addr_b),
      .ram_rd_data_i  (rd_data_b),
      .bit_code_o     (bit_code_b),
      .busy_o         (busy_b),
      .done_o         (done_b)
   );

   // Synchronous pixel RAMs: data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (rd_en_a) rd_data_a <= mem[rd_addr_a][23:0];
      if (rd_en_b) rd_data_b <= mem[rd_addr_b];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int eff(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   // Monitors: compare DUT activity against the scoreboard queues.
   always @(negedge clk) begin
      if (rst_n_i) begin
         if (exp_line.size() > 0) begin
            e_line = exp_line.pop_front();
            check("line_a", {29'd0, bit_code_a, busy_a, done_a}, {29'd0, e_line});
         end
         if (rd_en_a) begin
            if (exp_rd.size() == 0) check("rd_extra_a", {23'd0, 1'b1, rd_addr_a}, 32'd0);
            else                    check("rd_addr_a", {24'd0, rd_addr_a}, {24'd0, exp_rd.pop_front()});
         end
         if (done_a) done_cnt_a++;
         if (rd_en_b) begin
            if (exp_rd_b.size() == 0) check("rd_extra_b", {23'd0, 1'b1, rd_addr_b}, 32'd0);
            else                      check("rd_addr_b", {24'd0, rd_addr_b}, {24'd0, exp_rd_b.pop_front()});
         end
         if (busy_b) busy_cnt_b++;
      end
   end

   // Build the expected cycle trace of one frame from cycle k+1 onward.
   task automatic push_frame(input int npix, input int extra_idle);
      int h, l, g;
      logic [23:0] px;
      exp_line.push_back(3'b010);   // READ
      exp_line.push_back(3'b010);   // LOAD
      for (int p = 0; p < npix; p++) begin
         px = mem[p][23:0];
         for (int b = 23; b >= 0; b--) begin
            h = eff(px[b] ? int'(t1h) : int'(t0h));
            l = eff(px[b] ? int'(t1l) : int'(t0l));
            repeat (h) exp_line.push_back(3'b110);
            repeat (l) exp_line.push_back(3'b010);
         end
         exp_rd.push_back(p[7:0]);
      end
      g = eff(int'(reg_rst));
      repeat (g - 1) exp_line.push_back(3'b010);
      exp_line.push_back(3'b011);
      exp_line.push_back(3'b000);
      repeat (extra_idle) exp_line.push_back(3'b000);
   endtask

   task automatic pulse_start_a();
      @(posedge clk); #1 start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
   endtask

   task automatic start_frame_a(input int npix, input int extra_idle);
      pulse_start_a();
      push_frame(npix, extra_idle);
      frames_a++;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (exp_line.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check({tag, "_timeout"}, exp_line.size(), 32'd0);
      check({tag, "_rd_left"}, exp_rd.size(), 32'd0);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      rst_n_i = 1'b0;
      start_a = 1'b0; start_b = 1'b0;
      len_a = 8'd0; len_b = 8'd0;
      t0h = 8'd3; t0l = 8'd7; t1h = 8'd7; t1l = 8'd3; reg_rst = 16'd20;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_a", {20'd0, bit_code_a, busy_a, done_a, rd_en_a, rd_addr_a}, 32'd0);
      check("rst_b", {20'd0, bit_code_b, busy_b, done_b, rd_en_b, rd_addr_b}, 32'd0);
      @(posedge clk); #2 rst_n_i = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("idle_after_rst", {29'd0, bit_code_a, busy_a, done_a}, 32'd0);

      // Single pixel 0xA50000
      mem[0] = 32'h00A50000;
      len_a  = 8'd0;
      start_frame_a(1, 2);
      wait_drain("single", 2000);

      // Three pixels, back to back
      mem[0] = 32'h00FFFFFF; mem[1] = 32'h00000000; mem[2] = 32'h00123456;
      len_a  = 8'd2;
      start_frame_a(3, 2);
      wait_drain("three", 4000);

      // Start while busy: mid-frame and on the done cycle
      mem[0] = 32'h005A0F3C; mem[1] = 32'h00C3A596;
      len_a  = 8'd1;
      start_frame_a(2, 6);
      repeat (40) @(posedge clk);
      pulse_start_a();
      n = 0;
      while (!done_a && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("busy_done_seen", {31'd0, done_a}, 32'd1);
      start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      wait_drain("busy", 100);
      check("busy_done_cnt", done_cnt_a, frames_a);

      // Reset during pixel 1, bit 5 (high phase of a code-1 bit)
      mem[0] = 32'h00000000; mem[1] = 32'h00FFFFFF; mem[2] = 32'h00AAAAAA;
      len_a  = 8'd2;
      start_frame_a(3, 0);
      frames_a--;
      repeat (295) @(negedge clk);
      @(posedge clk); #2;
      check("pre_abort_high", {31'd0, bit_code_a}, 32'd1);
      exp_line.delete();
      exp_rd.delete();
      rst_n_i = 1'b0;
      #1 check("abort_outs", {20'd0, bit_code_a, busy_a, done_a, rd_en_a, rd_addr_a}, 32'd0);
      repeat (3) @(posedge clk);
      #2 rst_n_i = 1'b1;
      repeat (3) @(posedge clk);
      check("abort_no_done", done_cnt_a, frames_a);
      mem[0] = 32'h0081C3E7;
      len_a  = 8'd0;
      start_frame_a(1, 2);
      wait_drain("after_abort", 2000);

      // All timing values zero: every phase and the gap last one cycle
      t0h = 8'd0; t0l = 8'd0; t1h = 8'd0; t1l = 8'd0; reg_rst = 16'd0;
      mem[0] = 32'h00F0F00F; mem[1] = 32'h000FF0F0;
      len_a  = 8'd1;
      start_frame_a(2, 2);
      wait_drain("zero", 500);
      check("done_cnt_a", done_cnt_a, frames_a);

      // Full 256-pixel channel on the 32-bit instance
      len_b = 8'd255;
      busy_cnt_b = 0;
      for (int p = 0; p < 256; p++) exp_rd_b.push_back(p[7:0]);
      @(posedge clk); #1 start_b = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
      n = 0;
      while (!done_b && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("full_done_seen", {31'd0, done_b}, 32'd1);
      repeat (2) @(negedge clk);
      check("full_rd_left", exp_rd_b.size(), 32'd0);
      check("full_busy_cycles", busy_cnt_b, 2 + 256 * 32 * 2 + 1);
      check("full_idle", {31'd0, busy_b}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
